// File: rtl/muldiv_ctrl.sv
// EX-stage sequencer for the shared multiplier and divider: latches one
// mul/div op, stalls IF..EX until the result is back, then pulses a single HI/LO write.
module muldiv_ctrl #(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [3:0]  op_code,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        ex_hold,
    input  logic        flush,
    output logic        stallreq,
    output logic        busy,
    output logic        mul_signed,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_result,
    output logic        div_start,
    output logic        div_signed,
    output logic [31:0] div_opa,
    output logic [31:0] div_opb,
    output logic        div_annul,
    input  logic        div_ready,
    input  logic [63:0] div_result,
    output logic        hilo_we,
    output logic [31:0] hi_wdata,
    output logic [31:0] lo_wdata
);

    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   opa_q, opa_d, opb_q, opb_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic          sgn_q, sgn_d;
    logic          we_q, we_d;
    logic          annul_q, annul_d;

    logic op_onehot, is_op, is_mul, is_signed;

    // Anything other than exactly one bit set is not ours and must never stall.
    assign op_onehot = (op_code == 4'b1000) | (op_code == 4'b0100) |
                       (op_code == 4'b0010) | (op_code == 4'b0001);
    assign is_op     = op_valid & op_onehot;
    assign is_mul    = op_code[3] | op_code[2];
    assign is_signed = op_code[3] | op_code[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        sgn_d   = sgn_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        we_d    = 1'b0;
        annul_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_op && !flush) begin
                    opa_d = src1;
                    opb_d = src2;
                    sgn_d = is_signed;
                    if (is_mul) begin
                        state_d = MUL_WAIT;
                        cnt_d   = CW'(MUL_LAT - 1);
                    end else begin
                        state_d = DIV_WAIT;
                    end
                end
            end
            MUL_WAIT: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    hi_d    = mul_result[63:32];
                    lo_d    = mul_result[31:0];
                    we_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DIV_WAIT: begin
                // Flush beats a same-cycle div_ready: the killed op must not write.
                if (flush) begin
                    state_d = IDLE;
                    annul_d = 1'b1;
                end else if (div_ready) begin
                    hi_d    = div_result[63:32];
                    lo_d    = div_result[31:0];
                    we_d    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                // The op stays in EX while held; waiting here keeps it from re-issuing.
                if (flush || !ex_hold) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            sgn_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            we_q    <= 1'b0;
            annul_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sgn_q   <= sgn_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            we_q    <= we_d;
            annul_q <= annul_d;
        end
    end

    assign stallreq   = is_op & (state_q != DONE);
    assign busy       = (state_q != IDLE);
    assign mul_signed = sgn_q;
    assign mul_a      = opa_q;
    assign mul_b      = opb_q;
    assign div_signed = sgn_q;
    assign div_opa    = opa_q;
    assign div_opb    = opb_q;
    assign div_start  = (state_q == DIV_WAIT) & ~div_ready & ~flush;
    assign div_annul  = annul_q;
    assign hilo_we    = we_q;
    assign hi_wdata   = hi_q;
    assign lo_wdata   = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized bench for muldiv_ctrl: behavioural mul/div units plus a per-op
// reference of result, write count, latency, stall length and divider handshake.
module tb_muldiv_ctrl;
    localparam int MUL_LAT = 2;

    logic        clk = 1'b0;
    logic        rst, op_valid, ex_hold, flush;
    logic [3:0]  op_code;
    logic [31:0] src1, src2;
    logic        stallreq, busy, mul_signed, div_start, div_signed, div_annul, div_ready, hilo_we;
    logic [31:0] mul_a, mul_b, div_opa, div_opb, hi_wdata, lo_wdata;
    logic [63:0] mul_result, div_result;

    int checks = 0;
    int errors = 0;
    int div_cyc = 1;
    int dcnt = 0;

    always #5 clk = ~clk;

    muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code),
        .src1(src1), .src2(src2), .ex_hold(ex_hold), .flush(flush),
        .stallreq(stallreq), .busy(busy), .mul_signed(mul_signed),
        .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
        .div_start(div_start), .div_signed(div_signed), .div_opa(div_opa),
        .div_opb(div_opb), .div_annul(div_annul), .div_ready(div_ready),
        .div_result(div_result), .hilo_we(hilo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata)
    );

    // {hi, lo} an architectural MULT/MULTU/DIV/DIVU produces; x/0 gives q=all ones, r=dividend.
    function automatic logic [63:0] ref_hilo(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, m;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = '0;
        case (code)
            4'b1000: r = sa * sb;
            4'b0100: r = {32'b0, a} * {32'b0, b};
            4'b0010: if (b == 0) r = {a, 32'hFFFFFFFF};
                     else begin q = sa / sb; m = sa % sb; r = {m[31:0], q[31:0]}; end
            4'b0001: if (b == 0) r = {a, 32'hFFFFFFFF};
                     else r = {a % b, a / b};
            default: r = '0;
        endcase
        return r;
    endfunction

    // Mul unit: one register stage behind the latched operands.
    always_ff @(posedge clk) mul_result <= ref_hilo(mul_signed ? 4'b1000 : 4'b0100, mul_a, mul_b);

    // Div unit: ready once it has seen div_cyc cycles of div_start.
    always_comb div_result = ref_hilo(div_signed ? 4'b0010 : 4'b0001, div_opa, div_opb);
    assign div_ready = (dcnt == div_cyc);
    always_ff @(posedge clk) begin
        if (rst || div_annul || div_ready) dcnt <= 0;
        else if (div_start)                dcnt <= dcnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one op in EX at a negedge and follow it until it leaves EX.
    task automatic run_op(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                          input int dcyc, input int hold, input int flush_at);
        int we_n, start_n, annul_n, stall_n, we_at, held, last_wait;
        bit left, valid, is_mul, killed;
        logic [63:0] got, exp;
        div_cyc = dcyc;
        op_valid = 1'b1; op_code = code; src1 = a; src2 = b;
        we_n = 0; start_n = 0; annul_n = 0; stall_n = 0; we_at = -1; held = 0; left = 0;
        got = '0;
        for (int k = 0; k < 200 && !left; k++) begin
            flush = (k == flush_at);
            #1;
            ex_hold = busy && !stallreq && (held < hold);
            if (ex_hold) held++;
            if (hilo_we) begin
                we_n++;
                if (we_at < 0) we_at = k;
                got = {hi_wdata, lo_wdata};
            end
            start_n += int'(div_start);
            annul_n += int'(div_annul);
            stall_n += int'(stallreq);
            left = flush || (!stallreq && !ex_hold);
            @(negedge clk);
        end
        op_valid = 1'b0; flush = 1'b0; ex_hold = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            we_n    += int'(hilo_we);
            start_n += int'(div_start);
            annul_n += int'(div_annul);
            @(negedge clk);
        end
        chk("left_ex", 64'(left), 64'(1));
        chk("idle_after", 64'(busy), 64'(0));

        valid     = ($countones(code) == 1);
        is_mul    = code[3] | code[2];
        last_wait = is_mul ? MUL_LAT : dcyc + 1;
        killed    = (flush_at >= 0) && (flush_at <= last_wait);
        if (!valid) begin
            chk("noop_we", 64'(we_n), 64'(0));
            chk("noop_stall", 64'(stall_n), 64'(0));
            chk("noop_start", 64'(start_n), 64'(0));
        end else if (killed) begin
            chk("kill_we", 64'(we_n), 64'(0));
            chk("kill_annul", 64'(annul_n), 64'((!is_mul && flush_at >= 1) ? 1 : 0));
            chk("kill_start", 64'(start_n), 64'((!is_mul && flush_at >= 1) ? flush_at - 1 : 0));
        end else begin
            exp = ref_hilo(code, a, b);
            chk("we_count", 64'(we_n), 64'(1));
            chk("hilo", got, exp);
            chk("we_latency", 64'(we_at), 64'(is_mul ? MUL_LAT + 1 : dcyc + 2));
            chk("stall_len", 64'(stall_n), 64'(is_mul ? MUL_LAT + 1 : dcyc + 2));
            chk("start_len", 64'(start_n), 64'(is_mul ? 0 : dcyc));
            chk("annul", 64'(annul_n), 64'(0));
            chk("hold_len", 64'(held), 64'(hold));
        end
    endtask

    initial begin
        logic [3:0] codes [4];
        logic [3:0] c;
        logic [31:0] a, b;
        int fa, lw, we_seen;
        codes[0] = 4'b1000; codes[1] = 4'b0100; codes[2] = 4'b0010; codes[3] = 4'b0001;
        rst = 1'b1; op_valid = 1'b0; op_code = '0; src1 = '0; src2 = '0;
        ex_hold = 1'b0; flush = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_ctrl", {60'b0, stallreq, busy, hilo_we, div_annul}, 64'(0));
        chk("reset_div_start", 64'(div_start), 64'(0));
        chk("reset_hilo", {hi_wdata, lo_wdata}, 64'(0));
        chk("reset_ops", {mul_a, div_opb}, 64'(0));
        chk("reset_sign", {62'b0, mul_signed, div_signed}, 64'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op(4'b1000, 32'hFFFFFFFF, 32'd2, 1, 0, -1);
        run_op(4'b0100, 32'hFFFFFFFF, 32'd2, 1, 0, -1);
        run_op(4'b0010, 32'hFFFFFFF9, 32'd2, 33, 0, -1);
        run_op(4'b0001, 32'd1000, 32'd7, 5, 4, -1);
        run_op(4'b0010, 32'd100, 32'd3, 33, 0, 6);
        run_op(4'b0101, 32'd5, 32'd6, 3, 0, -1);
        run_op(4'b0001, 32'd9, 32'd0, 2, 0, -1);
        run_op(4'b0010, 32'h80000000, 32'hFFFFFFFF, 4, 0, -1);

        // Reset while in MUL_WAIT; the pipeline reset empties EX too.
        op_valid = 1'b1; op_code = 4'b1000; src1 = 32'd3; src2 = 32'd4;
        @(negedge clk);
        rst = 1'b1; op_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_stall", 64'(stallreq), 64'(0));
        we_seen = 0;
        for (int k = 0; k < 4; k++) begin
            #1 we_seen += int'(hilo_we) + int'(div_start);
            @(negedge clk);
        end
        chk("rst_no_we", 64'(we_seen), 64'(0));

        for (int n = 0; n < 60; n++) begin
            c = ($urandom_range(0, 7) == 0) ? 4'($urandom) : codes[$urandom_range(0, 3)];
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2: b = b & 32'hFF;
                default: ;
            endcase
            lw = (c[3] | c[2]) ? MUL_LAT : 41;
            fa = ($urandom_range(0, 3) == 0) ? $urandom_range(0, lw) : -1;
            run_op(c, a, b, $urandom_range(1, 40), $urandom_range(0, 3), fa);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
